multdiv_seq: RTL and testbench

- Multi-cycle signed 32x32 multiplier and 32/32 divider in the processor execute stage.
- Sits directly upstream of the 64-bit product/quotient holding register.
- Its 64-bit data_product output and one-cycle data_resultRDY strobe drive that register's data input and write enable.
- The low 32 bits plus an exception flag also return to the writeback path.

---
 rtl/multdiv_seq.sv | 176 +++++++++++++++++
 tb/tb_multdiv_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (Booth) / divide (restoring); result strobed 33 edges after start.
// Define MULTDIV_BOOTH4_EN for radix-4 Booth multiply (17-edge multiply latency; divide unchanged).
`timescale 1ns/1ps
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  output logic [WIDTH-1:0]   data_result,
  output logic [2*WIDTH-1:0] data_product,
  output logic               data_exception,
  output logic               data_resultRDY,
  output logic               busy
);
  // Two guard bits keep +/-2M partial products and the most negative multiplicand exact.
  localparam int ACCW = WIDTH + 2;
  localparam int CW   = $clog2(WIDTH);
`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_ITERS = WIDTH / 2;
`else
  localparam int MUL_ITERS = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [ACCW-1:0]  acc;
  logic [WIDTH-1:0] q, m;
  logic             qm1, neg_a, neg_b, div_zero, div_ovf;

  logic start, mul_last, div_last;
  assign start    = ctrl_MULT | ctrl_DIV;
  assign mul_last = (cnt == CW'(MUL_ITERS - 1));
  assign div_last = (cnt == CW'(WIDTH - 1));

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  logic [ACCW-1:0]  m_ext, booth_pp, booth_sum, mul_acc_nxt;
  logic [WIDTH-1:0] mul_q_nxt;
  logic             mul_qm1_nxt;
  assign m_ext = {{(ACCW-WIDTH){m[WIDTH-1]}}, m};

  always_comb begin
    booth_pp = '0;
`ifdef MULTDIV_BOOTH4_EN
    case ({q[1], q[0], qm1})
      3'b001, 3'b010: booth_pp = m_ext;
      3'b011:         booth_pp = m_ext << 1;
      3'b100:         booth_pp = -(m_ext << 1);
      3'b101, 3'b110: booth_pp = -m_ext;
      default:        booth_pp = '0;
    endcase
    booth_sum = acc + booth_pp;
    {mul_acc_nxt, mul_q_nxt, mul_qm1_nxt} = {{2{booth_sum[ACCW-1]}}, booth_sum, q[WIDTH-1:1]};
`else
    case ({q[0], qm1})
      2'b01:   booth_pp = m_ext;
      2'b10:   booth_pp = -m_ext;
      default: booth_pp = '0;
    endcase
    booth_sum = acc + booth_pp;
    {mul_acc_nxt, mul_q_nxt, mul_qm1_nxt} = {booth_sum[ACCW-1], booth_sum, q};
`endif
  end

  logic [2*WIDTH-1:0] mul_prod;
  logic               mul_exc;
  assign mul_prod = {mul_acc_nxt[WIDTH-1:0], mul_q_nxt};
  assign mul_exc  = (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}});

  // Restoring step: remainder lives in acc[WIDTH-1:0], dividend shifts out of q as quotient shifts in.
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_rem_nxt, div_q_nxt, quot_s, rem_s;
  assign div_trial = {acc[WIDTH-1:0], q[WIDTH-1]} - {1'b0, m};

  always_comb begin
    div_rem_nxt = {acc[WIDTH-2:0], q[WIDTH-1]};
    div_q_nxt   = {q[WIDTH-2:0], 1'b0};
    if (!div_trial[WIDTH]) begin
      div_rem_nxt = div_trial[WIDTH-1:0];
      div_q_nxt   = {q[WIDTH-2:0], 1'b1};
    end
  end

  assign quot_s = (neg_a ^ neg_b) ? -div_q_nxt : div_q_nxt;
  assign rem_s  = neg_a ? -div_rem_nxt : div_rem_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state)
        MUL:     if (mul_last) state_nxt = DONE;
        DIV:     if (div_last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy           = (state == MUL) || (state == DIV);
    data_resultRDY = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      acc            <= '0;
      q              <= '0;
      m              <= '0;
      qm1            <= 1'b0;
      neg_a          <= 1'b0;
      neg_b          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_product   <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      acc   <= '0;
      qm1   <= 1'b0;
      neg_a <= data_operandA[WIDTH-1];
      neg_b <= data_operandB[WIDTH-1];
      if (ctrl_MULT) begin
        m <= data_operandA;
        q <= data_operandB;
      end else begin
        m <= b_mag;
        q <= a_mag;
      end
      div_zero <= (data_operandB == '0);
      div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    end else if (state == MUL) begin
      cnt <= cnt + CW'(1);
      acc <= mul_acc_nxt;
      q   <= mul_q_nxt;
      qm1 <= mul_qm1_nxt;
      if (mul_last) begin
        data_result    <= mul_prod[WIDTH-1:0];
        data_product   <= mul_prod;
        data_exception <= mul_exc;
      end
    end else if (state == DIV) begin
      cnt <= cnt + CW'(1);
      acc <= {{(ACCW-WIDTH){1'b0}}, div_rem_nxt};
      q   <= div_q_nxt;
      if (div_last) begin
        if (div_zero) begin
          data_result    <= '0;
          data_product   <= '0;
          data_exception <= 1'b1;
        end else begin
          data_result    <= quot_s;
          data_product   <= {rem_s, quot_s};
          data_exception <= div_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: multiply/divide vectors, restart, reset abort, start priority.
`timescale 1ns/1ps
module tb_multdiv_seq;
`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic [63:0] data_product;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    logic        e;
  } vec_t;

  vec_t mv [7] = '{
    '{32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0},
    '{32'h00010000, 32'h00010000, 64'h00000001_00000000, 1'b1},
    '{32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b1},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 1'b0},
    '{32'h80000000, 32'h00000001, 64'hFFFFFFFF_80000000, 1'b0},
    '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1},
    '{32'h12345678, 32'h00000000, 64'h00000000_00000000, 1'b0}
  };

  vec_t dv [8] = '{
    '{32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 1'b0},
    '{32'h00000005, 32'h00000000, 64'h00000000_00000000, 1'b1},
    '{32'h00000064, 32'h00000007, 64'h00000002_0000000E, 1'b0},
    '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1},
    '{32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0},
    '{32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 1'b0},
    '{32'h80000000, 32'h00000002, 64'h00000000_C0000000, 1'b0},
    '{32'h00000003, 32'h0000000A, 64'h00000003_00000000, 1'b0}
  };

  always #5 clk = ~clk;

  multdiv_seq dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_product   (data_product),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Called at a falling edge; the start is taken at the next rising edge (edge 0).
  // Returns at the falling edge just before edge 1, with operands scrambled.
  task automatic start_op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(negedge clk);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Samples the values seen at edges 1..n; captures outputs at the first rdy.
  task automatic observe(input int n, output int first, output int cnt, output logic [31:0] res,
                         output logic [63:0] prod, output logic exc, output logic bsy);
    first = 0; cnt = 0; res = '0; prod = '0; exc = 1'b0; bsy = 1'b1;
    for (int i = 1; i <= n; i++) begin
      if (data_resultRDY === 1'b1) begin
        cnt++;
        if (first == 0) begin
          first = i; res = data_result; prod = data_product; exc = data_exception; bsy = busy;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (2) @(negedge clk);
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", data_result); end
    checks++; if (data_product !== 64'h0) begin errors++; $display("FAIL reset_product got %h exp 0", data_product); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b exp 0", data_exception); end
    checks++; if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", data_resultRDY); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    foreach (mv[k]) begin
      start_op(1'b1, 1'b0, mv[k].a, mv[k].b);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul%0d_busy got %b exp 1", k, busy); end
      observe(MUL_LAT + 7, first, cnt, res, prod, exc, bsy);
      checks++; if (first != MUL_LAT) begin errors++; $display("FAIL mul%0d_rdy_edge got %0d exp %0d", k, first, MUL_LAT); end
      checks++; if (cnt != 1) begin errors++; $display("FAIL mul%0d_rdy_count got %0d exp 1", k, cnt); end
      checks++; if (res !== mv[k].p[31:0]) begin errors++; $display("FAIL mul%0d_result got %h exp %h", k, res, mv[k].p[31:0]); end
      checks++; if (prod !== mv[k].p) begin errors++; $display("FAIL mul%0d_product got %h exp %h", k, prod, mv[k].p); end
      checks++; if (exc !== mv[k].e) begin errors++; $display("FAIL mul%0d_exc got %b exp %b", k, exc, mv[k].e); end
      checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL mul%0d_busy_done got %b exp 0", k, bsy); end
      checks++; if (data_product !== mv[k].p) begin errors++; $display("FAIL mul%0d_hold got %h exp %h", k, data_product, mv[k].p); end
    end
  endtask

  task automatic test_div();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    foreach (dv[k]) begin
      start_op(1'b0, 1'b1, dv[k].a, dv[k].b);
      observe(DIV_LAT + 7, first, cnt, res, prod, exc, bsy);
      checks++; if (first != DIV_LAT) begin errors++; $display("FAIL div%0d_rdy_edge got %0d exp %0d", k, first, DIV_LAT); end
      checks++; if (cnt != 1) begin errors++; $display("FAIL div%0d_rdy_count got %0d exp 1", k, cnt); end
      checks++; if (res !== dv[k].p[31:0]) begin errors++; $display("FAIL div%0d_result got %h exp %h", k, res, dv[k].p[31:0]); end
      checks++; if (prod !== dv[k].p) begin errors++; $display("FAIL div%0d_product got %h exp %h", k, prod, dv[k].p); end
      checks++; if (exc !== dv[k].e) begin errors++; $display("FAIL div%0d_exc got %b exp %b", k, exc, dv[k].e); end
      checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL div%0d_busy_done got %b exp 0", k, bsy); end
    end
  endtask

  task automatic test_restart();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    observe(9, first, cnt, res, prod, exc, bsy);
    checks++; if (cnt != 0) begin errors++; $display("FAIL restart_early_rdy got %0d exp 0", cnt); end
    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    observe(45, first, cnt, res, prod, exc, bsy);
    checks++; if (first + 10 != 43) begin errors++; $display("FAIL restart_rdy_edge got %0d exp 43", first + 10); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL restart_rdy_count got %0d exp 1", cnt); end
    checks++; if (res !== 32'd14) begin errors++; $display("FAIL restart_result got %h exp 0000000e", res); end
    checks++; if (prod !== 64'h00000002_0000000E) begin errors++; $display("FAIL restart_product got %h exp 000000020000000e", prod); end
  endtask

  task automatic test_reset_abort();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    start_op(1'b1, 1'b0, 32'd9, 32'd9);
    observe(14, first, cnt, res, prod, exc, bsy);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (data_result !== 32'h0) begin errors++; $display("FAIL abort_result got %h exp 0", data_result); end
    checks++; if (data_product !== 64'h0) begin errors++; $display("FAIL abort_product got %h exp 0", data_product); end
    checks++; if (data_exception !== 1'b0) begin errors++; $display("FAIL abort_exc got %b exp 0", data_exception); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    reset = 1'b0;
    observe(40, first, cnt, res, prod, exc, bsy);
    checks++; if (cnt != 0) begin errors++; $display("FAIL abort_rdy_count got %0d exp 0", cnt); end
  endtask

  task automatic test_both_start();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    start_op(1'b1, 1'b1, 32'd6, 32'd3);
    observe(MUL_LAT + 7, first, cnt, res, prod, exc, bsy);
    checks++; if (first != MUL_LAT) begin errors++; $display("FAIL both_rdy_edge got %0d exp %0d", first, MUL_LAT); end
    checks++; if (res !== 32'd18) begin errors++; $display("FAIL both_result got %h exp 00000012", res); end
    checks++; if (prod !== 64'd18) begin errors++; $display("FAIL both_product got %h exp 18", prod); end
  endtask

  task automatic test_back_to_back();
    int first, cnt; logic [31:0] res; logic [63:0] prod; logic exc, bsy;
    start_op(1'b1, 1'b0, 32'd2, 32'd3);
    observe(MUL_LAT - 1, first, cnt, res, prod, exc, bsy);
    checks++; if (data_resultRDY !== 1'b1) begin errors++; $display("FAIL b2b_first_rdy got %b exp 1", data_resultRDY); end
    checks++; if (data_result !== 32'd6) begin errors++; $display("FAIL b2b_first_result got %h exp 00000006", data_result); end
    start_op(1'b0, 1'b1, 32'd9, 32'd3);
    observe(DIV_LAT + 7, first, cnt, res, prod, exc, bsy);
    checks++; if (first != DIV_LAT) begin errors++; $display("FAIL b2b_rdy_edge got %0d exp %0d", first, DIV_LAT); end
    checks++; if (cnt != 1) begin errors++; $display("FAIL b2b_rdy_count got %0d exp 1", cnt); end
    checks++; if (prod !== 64'h00000000_00000003) begin errors++; $display("FAIL b2b_product got %h exp 3", prod); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_restart();
    test_reset_abort();
    test_both_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
